// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states and register-zero constant,
// also used by the forwarding logic.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A source depends on a destination only if it names the same non-zero register.
  function automatic logic reg_hazard(input logic [4:0] src, input logic [4:0] dst);
    return (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter with zero flag, timing multi-cycle data-memory stalls.
module mem_wait_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: PC/IF-ID/ID-EX enables, bubbles and flushes for load-use,
// taken branches and multi-cycle memory accesses, plus a saturating stall counter.
module hazard_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   mem_access,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   ex_mem_hold,
  output logic                   mem_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W      = $clog2(MEM_LATENCY + 1);
  localparam bit          MEM_STALLS = (MEM_LATENCY > 1);
  localparam int unsigned LOAD_VAL   = MEM_STALLS ? (MEM_LATENCY - 2) : 0;

  pipe_state_e             r_state;
  pipe_state_e             w_next;
  logic [STALL_CNT_W-1:0]  r_stall_cycles;
  logic                    w_load_use;
  logic                    w_tmr_load;
  logic                    w_tmr_dec;
  logic [CNT_W-1:0]        w_tmr_cnt;
  logic                    w_tmr_zero;

  mem_wait_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (CNT_W'(LOAD_VAL)),
    .i_dec      (w_tmr_dec),
    .o_cnt      (w_tmr_cnt),
    .o_zero     (w_tmr_zero)
  );

  assign w_load_use = ex_mem_read &&
                      (reg_hazard(id_rs, ex_rd) || (id_uses_rt && reg_hazard(id_rt, ex_rd)));

  // Reset overrides everything so the same-cycle outputs match the reset state.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    mem_busy     = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    w_next       = r_state;
    if (rst) begin
      w_next = RUN;
    end else if (r_state == MEM_WAIT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
      mem_busy    = 1'b1;
      w_tmr_dec   = 1'b1;
      if (w_tmr_zero || (w_tmr_cnt == CNT_W'(1))) begin
        w_next = MEM_DONE;
      end
    end else if ((r_state == RUN) && mem_access && MEM_STALLS) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
      mem_busy    = 1'b1;
      w_tmr_load  = 1'b1;
      w_next      = (LOAD_VAL != 0) ? MEM_WAIT : MEM_DONE;
    end else begin
      if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      w_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next;
      if (!pc_write && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and random checks of hazard_stall_controller against a cycle-level
// reference model that tracks remaining memory-stall cycles as a plain integer.
module tb_hazard_stall_controller;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 16;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_access;
  logic          pc_write, if_id_write, id_ex_write, id_ex_bubble;
  logic          if_id_flush, ex_mem_hold, mem_busy;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rem  = 0;
  bit m_done = 0;
  int m_cnt  = 0;

  hazard_stall_controller #(
    .MEM_LATENCY(LAT),
    .STALL_CNT_W(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .ex_mem_hold     (ex_mem_hold),
    .mem_busy        (mem_busy),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare combinational outputs to the model, then advance.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] rd, input logic mr,
                      input logic br, input logic ma);
    logic e_pc, e_ifw, e_idw, e_bub, e_fl, e_hold, e_busy;
    bit   lu;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = br; mem_access = ma;
    #2;
    {e_pc, e_ifw, e_idw} = 3'b111;
    {e_bub, e_fl, e_hold, e_busy} = 4'b0000;
    lu = mr && (rd != 0) && ((rs == rd) || (urt && (rt == rd)));
    if (r) begin
      m_rem = 0; m_done = 0; m_cnt = 0;
    end else if (m_rem > 0) begin
      {e_pc, e_ifw, e_idw, e_hold, e_busy} = 5'b00011;
      m_rem--;
      m_done = (m_rem == 0);
    end else if (ma && !m_done && LAT > 1) begin
      {e_pc, e_ifw, e_idw, e_hold, e_busy} = 5'b00011;
      m_rem  = LAT - 2;
      m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      if (br) begin
        e_bub = 1; e_fl = 1;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end
    end
    check("pc_write",     32'(pc_write),     32'(e_pc));
    check("if_id_write",  32'(if_id_write),  32'(e_ifw));
    check("id_ex_write",  32'(id_ex_write),  32'(e_idw));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("if_id_flush",  32'(if_id_flush),  32'(e_fl));
    check("ex_mem_hold",  32'(ex_mem_hold),  32'(e_hold));
    check("mem_busy",     32'(mem_busy),     32'(e_busy));
    check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    if (!r && !e_pc && m_cnt < SAT) m_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    step(r, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b0;

    // Reset state
    idle(1'b1);
    idle(1'b0);
    check("reset_cnt", 32'(stall_cycles), 32'd0);

    // 1: load-use on rs stalls exactly one cycle
    step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("t1_cnt", 32'(stall_cycles), 32'd1);

    // 2: register zero and unused rt never stall
    step(1'b0, 5'd0, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // 3: branch taken wins over load-use
    step(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // 4: memory access held 4 cycles -> 3 stall cycles, no retrigger
    idle(1'b1);
    for (int unsigned i = 0; i < 4; i++)
      step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    check("t4_cnt", 32'(stall_cycles), 32'd3);
    idle(1'b0);

    // 5: reset in the second wait cycle
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    check("t5_cnt", 32'(stall_cycles), 32'd0);
    idle(1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Random traffic with narrow register range for frequent hazards
    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // 6: saturation of the stall counter
    idle(1'b1);
    for (int unsigned i = 0; i < (1 << CW) + 5; i++)
      step(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t6_sat", 32'(stall_cycles), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
